// File: rtl/ex_wb_pipe_regs_pkg.sv
// Shared widths, stage record and load-use FSM encoding for the EX/MEM and MEM/WB registers.
`default_nettype none

package pipe_pkg;

   localparam int REG_AW = 4;
   localparam int DATA_W = 16;

   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } lu_state_t;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              we;
      logic              is_load;
      logic [DATA_W-1:0] data;
   } stage_t;

   localparam stage_t STAGE_EMPTY = '0;

endpackage

`default_nettype wire

// File: rtl/ex_wb_pipe_regs_if.sv
// Pipeline-side bundle of the EX/MEM and MEM/WB registers: ID/EX capture inputs, forward and write-back outputs.
`default_nettype none

interface ex_wb_pipe_regs_if
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
);
   logic              hold;
   logic              flush;
   logic              idex_valid;
   logic [REG_AW-1:0] idex_rd;
   logic              idex_we;
   logic              idex_is_load;
   logic [DATA_W-1:0] ex_result;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [DATA_W-1:0] mem_rdata;

   logic [REG_AW-1:0] exmem_rd;
   logic              exmem_we;
   logic [DATA_W-1:0] fwd_exmem_data;
   logic [REG_AW-1:0] memwb_rd;
   logic              memwb_we;
   logic [DATA_W-1:0] fwd_memwb_data;
   logic              wb_we;
   logic [REG_AW-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              load_use_stall;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output hold, flush, idex_valid, idex_rd, idex_we, idex_is_load, ex_result,
             id_rs, id_rt, mem_rdata,
      input  exmem_rd, exmem_we, fwd_exmem_data, memwb_rd, memwb_we, fwd_memwb_data,
             wb_we, wb_rd, wb_data, load_use_stall, stall_cnt
   );

   modport slave (
      input  hold, flush, idex_valid, idex_rd, idex_we, idex_is_load, ex_result,
             id_rs, id_rt, mem_rdata,
      output exmem_rd, exmem_we, fwd_exmem_data, memwb_rd, memwb_we, fwd_memwb_data,
             wb_we, wb_rd, wb_data, load_use_stall, stall_cnt
   );

endinterface

`default_nettype wire

// File: rtl/ex_wb_pipe_regs_stage_reg.sv
// Generic pipeline stage register; flush outranks hold, reset is asynchronous active-low.
`default_nettype none

module pipe_stage_reg
   import pipe_pkg::*;
(
   input  wire    clk,
   input  wire    rst,
   input  wire    hold,
   input  wire    flush,
   input  stage_t d,
   output stage_t q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= STAGE_EMPTY;
      end else if (flush) begin
         q <= STAGE_EMPTY;
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ex_wb_pipe_regs.sv
// EX/MEM and MEM/WB pipeline registers with register-file write-back and load-use stall control.
`default_nettype none

module ex_wb_pipe_regs
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input wire               clk,
   input wire               rst,
   ex_wb_pipe_regs_if.slave bus
);

   stage_t          exmem_d;
   stage_t          exmem_q;
   stage_t          memwb_d;
   stage_t          memwb_q;
   logic            cap_we;
   logic            hit;
   logic            stall;
   lu_state_t       state_q;
   lu_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic            memwb_is_load_unused;

   // Writes to r0 are dropped here so the forwarding unit never matches on r0.
   assign cap_we = bus.idex_valid & bus.idex_we & (bus.idex_rd != REG_ZERO);

   always_comb begin
      exmem_d         = STAGE_EMPTY;
      exmem_d.valid   = bus.idex_valid;
      exmem_d.rd      = bus.idex_rd;
      exmem_d.we      = cap_we;
      exmem_d.is_load = bus.idex_is_load;
      exmem_d.data    = bus.ex_result;

      memwb_d         = STAGE_EMPTY;
      memwb_d.valid   = exmem_q.valid;
      memwb_d.rd      = exmem_q.rd;
      memwb_d.we      = exmem_q.we;
      memwb_d.is_load = exmem_q.is_load;
      memwb_d.data    = exmem_q.is_load ? bus.mem_rdata : exmem_q.data;
   end

   pipe_stage_reg u_exmem (
      .clk   (clk),
      .rst   (rst),
      .hold  (bus.hold),
      .flush (bus.flush),
      .d     (exmem_d),
      .q     (exmem_q)
   );

   pipe_stage_reg u_memwb (
      .clk   (clk),
      .rst   (rst),
      .hold  (bus.hold),
      .flush (1'b0),
      .d     (memwb_d),
      .q     (memwb_q)
   );

   assign memwb_is_load_unused = memwb_q.is_load;

   assign hit = bus.idex_valid & bus.idex_is_load & cap_we &
                ((bus.idex_rd == bus.id_rs) | (bus.idex_rd == bus.id_rt));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // BUBBLE suppresses a second stall while the same load is still visible in ID/EX.
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         ST_RUN: begin
            stall = hit & ~bus.hold;
            if (stall) begin
               state_d = ST_BUBBLE;
            end
         end
         ST_BUBBLE: begin
            if (!bus.hold) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.exmem_rd       = exmem_q.rd;
   assign bus.exmem_we       = exmem_q.we;
   assign bus.fwd_exmem_data = exmem_q.data;
   assign bus.memwb_rd       = memwb_q.rd;
   assign bus.memwb_we       = memwb_q.we;
   assign bus.fwd_memwb_data = memwb_q.data;
   assign bus.wb_we          = memwb_q.valid & memwb_q.we & ~bus.hold;
   assign bus.wb_rd          = memwb_q.rd;
   assign bus.wb_data        = memwb_q.data;
   assign bus.load_use_stall = stall;
   assign bus.stall_cnt      = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_wb_pipe_regs.sv
// Directed self-checking bench for ex_wb_pipe_regs with hand-computed expectations.
`default_nettype none

module tb_ex_wb_pipe_regs;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   ex_wb_pipe_regs_if #(.CNT_W(16)) bus ();

   ex_wb_pipe_regs #(.CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] rd, input logic we,
                        input logic ld, input logic [15:0] res);
      bus.idex_valid   = v;
      bus.idex_rd      = rd;
      bus.idex_we      = we;
      bus.idex_is_load = ld;
      bus.ex_result    = res;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      bus.hold = 1'b0;
      bus.flush = 1'b0;
      bus.id_rs = '0;
      bus.id_rt = '0;
      bus.mem_rdata = '0;
      drive(1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
      repeat (2) tick();

      // reset state
      check("rst_exmem_we", bus.exmem_we, 0);
      check("rst_memwb_we", bus.memwb_we, 0);
      check("rst_wb_we", bus.wb_we, 0);
      check("rst_stall", bus.load_use_stall, 0);
      check("rst_cnt", bus.stall_cnt, 0);
      rst = 1'b1;

      // 1: ALU op rd=3
      drive(1'b1, 4'd3, 1'b1, 1'b0, 16'h1234);
      tick();
      check("t1_exmem_rd", bus.exmem_rd, 3);
      check("t1_exmem_we", bus.exmem_we, 1);
      check("t1_exmem_data", bus.fwd_exmem_data, 16'h1234);
      check("t1_wb_we_early", bus.wb_we, 0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
      tick();
      check("t1_wb_we", bus.wb_we, 1);
      check("t1_wb_rd", bus.wb_rd, 3);
      check("t1_wb_data", bus.wb_data, 16'h1234);
      check("t1_exmem_we_bubble", bus.exmem_we, 0);

      // 2: load r5 followed by a user of r5
      bus.id_rs = 4'd5;
      bus.mem_rdata = 16'hBEEF;
      drive(1'b1, 4'd5, 1'b1, 1'b1, 16'h0040);
      #1;
      check("t2_stall_on", bus.load_use_stall, 1);
      tick();
      check("t2_stall_bubble", bus.load_use_stall, 0);
      check("t2_cnt", bus.stall_cnt, 1);
      check("t2_exmem_rd", bus.exmem_rd, 5);
      check("t2_exmem_data", bus.fwd_exmem_data, 16'h0040);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
      bus.id_rs = 4'd0;
      tick();
      check("t2_wb_we", bus.wb_we, 1);
      check("t2_wb_rd", bus.wb_rd, 5);
      check("t2_wb_data", bus.wb_data, 16'hBEEF);
      check("t2_stall_off", bus.load_use_stall, 0);
      check("t2_cnt_hold", bus.stall_cnt, 1);
      bus.mem_rdata = 16'h0000;

      // 3: load into r0 matching id_rs=0 must neither write nor stall
      drive(1'b1, 4'd0, 1'b1, 1'b1, 16'h5555);
      #1;
      check("t3_no_stall", bus.load_use_stall, 0);
      tick();
      check("t3_exmem_we", bus.exmem_we, 0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
      tick();
      check("t3_wb_we", bus.wb_we, 0);

      // 4: hold with r7 in EX/MEM and r2 in MEM/WB
      drive(1'b1, 4'd2, 1'b1, 1'b0, 16'h2222);
      tick();
      drive(1'b1, 4'd7, 1'b1, 1'b0, 16'h7777);
      tick();
      check("t4_pre_exmem_rd", bus.exmem_rd, 7);
      check("t4_pre_memwb_rd", bus.memwb_rd, 2);
      check("t4_pre_wb_we", bus.wb_we, 1);
      bus.hold = 1'b1;
      drive(1'b1, 4'd9, 1'b1, 1'b0, 16'h9999);
      #1;
      check("t4_wb_we_held", bus.wb_we, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_exmem_rd", bus.exmem_rd, 7);
         check("t4_memwb_rd", bus.memwb_rd, 2);
         check("t4_wb_we", bus.wb_we, 0);
      end
      check("t4_exmem_data", bus.fwd_exmem_data, 16'h7777);
      check("t4_memwb_data", bus.fwd_memwb_data, 16'h2222);
      bus.hold = 1'b0;
      tick();
      check("t4_resume_memwb_rd", bus.memwb_rd, 7);
      check("t4_resume_wb_we", bus.wb_we, 1);
      check("t4_resume_wb_data", bus.wb_data, 16'h7777);
      check("t4_resume_exmem_rd", bus.exmem_rd, 9);

      // 5: flush together with hold, then flush together with a load-use hit
      bus.hold = 1'b1;
      bus.flush = 1'b1;
      drive(1'b1, 4'd4, 1'b1, 1'b0, 16'h4444);
      tick();
      check("t5_exmem_we", bus.exmem_we, 0);
      check("t5_exmem_rd", bus.exmem_rd, 0);
      check("t5_memwb_rd", bus.memwb_rd, 7);
      check("t5_memwb_we", bus.memwb_we, 1);
      check("t5_memwb_data", bus.fwd_memwb_data, 16'h7777);
      bus.hold = 1'b0;
      bus.id_rs = 4'd1;
      bus.id_rt = 4'd6;
      drive(1'b1, 4'd6, 1'b1, 1'b1, 16'h0066);
      #1;
      check("t5_flush_hit_stall", bus.load_use_stall, 1);
      tick();
      check("t5_cnt", bus.stall_cnt, 2);
      check("t5_exmem_we_flushed", bus.exmem_we, 0);
      check("t5_memwb_we", bus.memwb_we, 0);
      bus.flush = 1'b0;
      bus.id_rs = 4'd0;
      bus.id_rt = 4'd0;
      drive(1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
      tick();

      // 6: asynchronous reset mid-stream
      drive(1'b1, 4'd3, 1'b1, 1'b0, 16'h3333);
      tick();
      tick();
      check("t6_pre_wb_we", bus.wb_we, 1);
      #2;
      rst = 1'b0;
      #1;
      check("t6_wb_we", bus.wb_we, 0);
      check("t6_exmem_we", bus.exmem_we, 0);
      check("t6_memwb_we", bus.memwb_we, 0);
      check("t6_exmem_rd", bus.exmem_rd, 0);
      check("t6_exmem_data", bus.fwd_exmem_data, 0);
      check("t6_wb_data", bus.wb_data, 0);
      check("t6_cnt", bus.stall_cnt, 0);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
      tick();
      rst = 1'b1;
      bus.id_rs = 4'd8;
      drive(1'b1, 4'd8, 1'b1, 1'b1, 16'h0080);
      #1;
      check("t6_run_stall", bus.load_use_stall, 1);
      tick();
      check("t6_cnt_after", bus.stall_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
